enoc_switch_allocator: RTL and testbench
========================================

ENOC_SWITCH_ALLOCATOR -- requirements
Module: enoc_switch_allocator

Interface
REQ-001 SHALL have parameter PORTS, default 7, meaning router port count in order [c,n,e,s,w,u,d] (index 0 = c).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port i_output_req  input  PORTS x PORTS  i_output_req[i][o]: input i requests output o, one-hot or zero per input, from that input's route calculator.
REQ-005 SHALL have port i_tail  input  PORTS  head-of-queue flit at input i is a tail flit (single-flit packet = head and tail).
REQ-006 SHALL have port i_output_en  input  PORTS  output o can accept a flit this cycle (downstream space).
REQ-007 SHALL have port o_output_grant  output  PORTS x PORTS  o_output_grant[o][i]: crossbar select, input i drives output o this cycle, one-hot or zero per output.
REQ-008 SHALL have port o_input_grant  output  PORTS  input i's flit is transferred this cycle (FIFO pop), OR over o of o_output_grant[o][i].

Function
REQ-009 SHALL keep per output o: lock bit, owner index (log2(PORTS) bits), round-robin pointer (log2(PORTS) bits).
REQ-010 SHALL derive grants combinationally from current state and inputs (zero-cycle grant latency); state updates registered.
REQ-011 Output o IDLE (lock=0) and i_output_en[o]=1: SHALL grant the first requesting input at or after pointer, searching upward mod PORTS.
REQ-012 On an IDLE grant to input w: pointer SHALL become (w+1) mod PORTS; if i_tail[w]=0, lock SHALL set with owner=w.
REQ-013 Output o LOCKED: SHALL grant only owner, only when i_output_req[owner][o]=1 and i_output_en[o]=1; other requesters get nothing.
REQ-014 LOCKED grant with i_tail[owner]=1: lock SHALL clear next cycle; pointer unchanged by locked grants.
REQ-015 LOCKED with owner not requesting: no grant, lock held (bubble), no state change.
REQ-016 i_output_en[o]=0: no grant on o, no change to lock, owner or pointer.
REQ-017 No requests on an IDLE output: no grant, pointer unchanged.
REQ-018 Lock release and new competing requests in same cycle: new arbitration SHALL occur from the next cycle using the pointer.
REQ-019 Pointer wrap: pointer PORTS-1 searches PORTS-1, 0, 1, ...; winner PORTS-1 sets pointer to 0.
REQ-020 Outputs SHALL arbitrate independently; one input granted by at most one output because requests are one-hot.
REQ-021 Request vectors with more than one bit set are illegal; behaviour undefined; bench asserts against them.

Reset
REQ-022 reset high SHALL asynchronously clear all locks, owners and pointers to 0.
REQ-023 During reset, o_output_grant and o_input_grant SHALL be all zero.
REQ-024 Reset mid-packet SHALL drop locks; first cycle after release arbitrates from pointer 0.

Configuration
REQ-025 Macro ENOC_WORMHOLE_LOCK_EN defined: locking per REQ-012..REQ-015 (wormhole, multi-flit packets).
REQ-026 ENOC_WORMHOLE_LOCK_EN undefined: lock/owner omitted, i_tail ignored, every flit arbitrated per REQ-011/REQ-012 independently.

Verification
REQ-027 Inputs 1,2,4 request output 0 every cycle, all i_tail=1, en=1 -> grants 1,2,4,1,2,4 on consecutive cycles.
REQ-028 Lock on: input 3 requests output 2 with i_tail 0,0,1; input 1 also requests output 2 -> input 3 granted 3 consecutive cycles, input 1 granted 4th cycle.
REQ-029 Lock on, input 3 owns output 2, i_output_en[2]=0 for 2 cycles then 1 -> no grants 2 cycles, input 3 resumes; input 1 not granted meanwhile.
REQ-030 Pointer at 6, inputs 6 and 0 request output 1 with tail=1 -> grant 6 then 0, pointer ends at 1.
REQ-031 Assert reset mid-packet (input 3 locked on output 2), release -> all grants 0 during reset; next cycle input 0 and 3 both request output 2 -> input 0 wins.
REQ-032 Lock off: REQ-028 stimulus -> grants alternate 3,1,3 (tail ignored).

Source files
------------

// File: rtl/enoc_switch_allocator.sv
// Per-output round-robin switch allocator with zero-cycle grants; i_output_en low stalls an output without state change.
// ENOC_WORMHOLE_LOCK_EN: hold an output for its owner from a non-tail grant until the owner's tail flit passes.
module enoc_switch_allocator #(
   parameter int PORTS = 7
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [PORTS-1:0][PORTS-1:0] i_output_req,
   input  logic [PORTS-1:0]            i_tail,
   input  logic [PORTS-1:0]            i_output_en,
   output logic [PORTS-1:0][PORTS-1:0] o_output_grant,
   output logic [PORTS-1:0]            o_input_grant
);
   localparam int PW = (PORTS > 1) ? $clog2(PORTS) : 1;

   logic [PORTS-1:0][PW-1:0]    ptr_q, ptr_d;
   logic [PORTS-1:0][PORTS-1:0] req_by_out;
   logic [PORTS-1:0][PORTS-1:0] grant;
`ifdef ENOC_WORMHOLE_LOCK_EN
   logic [PORTS-1:0]            lock_q, lock_d;
   logic [PORTS-1:0][PW-1:0]    owner_q, owner_d;
`else
   logic                        unused_tail;
   assign unused_tail = ^i_tail;
`endif

   always_comb begin
      req_by_out = '0;
      for (int i = 0; i < PORTS; i++)
         for (int o = 0; o < PORTS; o++)
            req_by_out[o][i] = i_output_req[i][o];
   end

   always_comb begin
      int          idx;
      logic [PW-1:0] win;
      logic        found;
      grant = '0;
      ptr_d = ptr_q;
`ifdef ENOC_WORMHOLE_LOCK_EN
      lock_d  = lock_q;
      owner_d = owner_q;
`endif
      idx   = 0;
      win   = '0;
      found = 1'b0;
      for (int o = 0; o < PORTS; o++) begin
         found = 1'b0;
         win   = '0;
         if (!reset && i_output_en[o]) begin
`ifdef ENOC_WORMHOLE_LOCK_EN
            // A locked output serves only its owner; an idle owner leaves a bubble.
            if (lock_q[o]) begin
               if (req_by_out[o][owner_q[o]]) begin
                  grant[o][owner_q[o]] = 1'b1;
                  if (i_tail[owner_q[o]])
                     lock_d[o] = 1'b0;
               end
            end else begin
`else
            begin
`endif
               for (int k = 0; k < PORTS; k++) begin
                  idx = int'(ptr_q[o]) + k;
                  if (idx >= PORTS)
                     idx = idx - PORTS;
                  if (!found && req_by_out[o][PW'(idx)]) begin
                     found = 1'b1;
                     win   = PW'(idx);
                  end
               end
               if (found) begin
                  grant[o][win] = 1'b1;
                  ptr_d[o] = (win == PW'(PORTS - 1)) ? '0 : win + 1'b1;
`ifdef ENOC_WORMHOLE_LOCK_EN
                  if (!i_tail[win]) begin
                     lock_d[o]  = 1'b1;
                     owner_d[o] = win;
                  end
`endif
               end
            end
         end
      end
   end

   assign o_output_grant = grant;

   always_comb begin
      o_input_grant = '0;
      for (int o = 0; o < PORTS; o++)
         o_input_grant = o_input_grant | grant[o];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr_q   <= '0;
`ifdef ENOC_WORMHOLE_LOCK_EN
         lock_q  <= '0;
         owner_q <= '0;
`endif
      end else begin
         ptr_q   <= ptr_d;
`ifdef ENOC_WORMHOLE_LOCK_EN
         lock_q  <= lock_d;
         owner_q <= owner_d;
`endif
      end
   end
endmodule

// File: tb/tb_enoc_switch_allocator.sv
// Directed bench for enoc_switch_allocator; expectations follow ENOC_WORMHOLE_LOCK_EN when defined.
module tb_enoc_switch_allocator;
   localparam int P = 7;
   typedef logic [P-1:0][P-1:0] mat_t;
`ifdef ENOC_WORMHOLE_LOCK_EN
   localparam bit LOCK = 1'b1;
`else
   localparam bit LOCK = 1'b0;
`endif
   localparam logic [P-1:0] ALL    = 7'b1111111;
   localparam logic [P-1:0] EN_NO0 = 7'b1111110;
   localparam logic [P-1:0] EN_NO2 = 7'b1111011;
   localparam logic [P-1:0] T3_0   = 7'b1110111;

   logic         clk, reset;
   mat_t         i_output_req, o_output_grant;
   logic [P-1:0] i_tail, i_output_en, o_input_grant;
   int           n_assert = 0;
   int           n_fail   = 0;
   int           rr_exp[6] = '{1, 2, 4, 1, 2, 4};

   enoc_switch_allocator #(.PORTS(P)) dut (
      .clk            (clk),
      .reset          (reset),
      .i_output_req   (i_output_req),
      .i_tail         (i_tail),
      .i_output_en    (i_output_en),
      .o_output_grant (o_output_grant),
      .o_input_grant  (o_input_grant)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   function automatic mat_t r(input int i, input int o);
      mat_t m;
      m = '0;
      m[i][o] = 1'b1;
      return m;
   endfunction

   task automatic apply(input logic rst, input mat_t req, input logic [P-1:0] tail,
                        input logic [P-1:0] en);
      @(negedge clk);
      reset = rst;
      i_output_req = req;
      i_tail = tail;
      i_output_en = en;
      #2;
      for (int i = 0; i < P; i++) begin
         n_assert++;
         assert ($onehot0(req[i])) else begin
            n_fail++;
            $error("FAIL req_onehot: input %0d observed %b required one-hot or zero", i, req[i]);
         end
      end
   endtask

   task automatic chk_out(input string tag, input int o, input int i);
      logic [P-1:0] exp;
      exp = '0;
      if (i >= 0) exp[i] = 1'b1;
      n_assert++;
      assert (o_output_grant[o] === exp) else begin
         n_fail++;
         $error("FAIL %s: o_output_grant[%0d] observed %b expected %b", tag, o, o_output_grant[o], exp);
      end
   endtask

   task automatic chk_in(input string tag, input logic [P-1:0] exp);
      n_assert++;
      assert (o_input_grant === exp) else begin
         n_fail++;
         $error("FAIL %s: o_input_grant observed %b expected %b", tag, o_input_grant, exp);
      end
   endtask

   task automatic chk_zero(input string tag);
      n_assert++;
      assert (o_output_grant === '0) else begin
         n_fail++;
         $error("FAIL %s: o_output_grant observed %h expected 0", tag, o_output_grant);
      end
      chk_in({tag, "_in"}, '0);
   endtask

   initial begin
      mat_t m;
      reset = 1'b1;
      i_output_req = r(1, 0) | r(3, 2);
      i_tail = ALL;
      i_output_en = ALL;
      #2;
      chk_zero("reset_hold");
      apply(1'b1, r(1, 0) | r(3, 2), ALL, ALL);
      chk_zero("reset_edge");

      // Round robin among inputs 1,2,4 on output 0
      m = r(1, 0) | r(2, 0) | r(4, 0);
      for (int k = 0; k < 6; k++) begin
         apply(1'b0, m, ALL, ALL);
         chk_out($sformatf("rr_%0d", k), 0, rr_exp[k]);
         chk_in($sformatf("rr_in_%0d", k), 7'(1 << rr_exp[k]));
      end
      apply(1'b0, m, ALL, EN_NO0);
      chk_out("en_off", 0, -1);
      chk_in("en_off_in", '0);
      apply(1'b0, m, ALL, ALL);
      chk_out("en_resume", 0, 1);
      apply(1'b0, '0, ALL, ALL);
      chk_zero("no_req");
      apply(1'b0, r(2, 0) | r(4, 0), ALL, ALL);
      chk_out("idle_ptr", 0, 2);

      // Pointer wrap on output 1
      apply(1'b0, r(5, 1), ALL, ALL);
      chk_out("wrap_setup", 1, 5);
      apply(1'b0, r(6, 1) | r(0, 1), ALL, ALL);
      chk_out("wrap_6", 1, 6);
      apply(1'b0, r(6, 1) | r(0, 1), ALL, ALL);
      chk_out("wrap_0", 1, 0);
      apply(1'b0, r(0, 1) | r(1, 1), ALL, ALL);
      chk_out("wrap_ptr1", 1, 1);

      // Independent outputs
      apply(1'b0, r(0, 3) | r(2, 4) | r(3, 3), ALL, ALL);
      chk_out("par_o3_a", 3, 0);
      chk_out("par_o4_a", 4, 2);
      chk_in("par_in_a", 7'b0000101);
      apply(1'b0, r(0, 3) | r(2, 4) | r(3, 3), ALL, ALL);
      chk_out("par_o3_b", 3, 3);
      chk_out("par_o4_b", 4, 2);
      chk_in("par_in_b", 7'b0001100);

      // Packet of 3 flits from input 3 on output 2, input 1 competing
      apply(1'b0, r(3, 2), T3_0, ALL);
      chk_out("pkt_c1", 2, 3);
      apply(1'b0, r(3, 2) | r(1, 2), T3_0, ALL);
      chk_out("pkt_c2", 2, LOCK ? 3 : 1);
      chk_in("pkt_c2_in", LOCK ? 7'b0001000 : 7'b0000010);
      apply(1'b0, r(3, 2) | r(1, 2), ALL, ALL);
      chk_out("pkt_c3", 2, 3);
      apply(1'b0, r(1, 2), ALL, ALL);
      chk_out("pkt_c4", 2, 1);

      // Output stall while input 3 holds output 2
      apply(1'b0, r(3, 2), T3_0, ALL);
      chk_out("stall_head", 2, 3);
      for (int k = 0; k < 2; k++) begin
         apply(1'b0, r(3, 2) | r(1, 2), T3_0, EN_NO2);
         chk_out($sformatf("stall_%0d", k), 2, -1);
         chk_in($sformatf("stall_in_%0d", k), '0);
      end
      apply(1'b0, r(3, 2) | r(1, 2), ALL, ALL);
      chk_out("stall_resume", 2, LOCK ? 3 : 1);
      apply(1'b0, r(1, 2), ALL, ALL);
      chk_out("stall_after", 2, 1);

      // Owner bubble, then reset mid-packet
      apply(1'b0, r(3, 2), T3_0, ALL);
      chk_out("mid_head", 2, 3);
      apply(1'b0, r(0, 2), ALL, ALL);
      chk_out("bubble", 2, LOCK ? -1 : 0);
      #1 reset = 1'b1;
      #1 chk_zero("reset_async");
      apply(1'b1, r(0, 2) | r(3, 2), ALL, ALL);
      chk_zero("reset_mid");
      apply(1'b0, r(0, 2) | r(3, 2), ALL, ALL);
      chk_out("post_reset", 2, 0);
      chk_in("post_reset_in", 7'b0000001);
      apply(1'b0, r(0, 2) | r(3, 2), ALL, ALL);
      chk_out("post_reset_next", 2, 3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
